// File: rtl/muldiv_sequencer_pkg.sv
// Shared ALU selection codes and small decode helpers for the RV32M sequencer.
// Only the codes this block decodes are mirrored here.
package muldiv_sequencer_pkg;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_MUL    = 5'd16;
  localparam logic [4:0] ALU_MULH   = 5'd17;
  localparam logic [4:0] ALU_MULHSU = 5'd18;
  localparam logic [4:0] ALU_MULHU  = 5'd19;
  localparam logic [4:0] ALU_DIV    = 5'd20;
  localparam logic [4:0] ALU_DIVU   = 5'd21;
  localparam logic [4:0] ALU_REM    = 5'd22;
  localparam logic [4:0] ALU_REMU   = 5'd23;

  function automatic logic is_m_op(input logic [4:0] sel);
    return sel inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                       ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

  function automatic logic is_mul_op(input logic [4:0] sel);
    return sel inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
  endfunction

  function automatic logic is_signed_div(input logic [4:0] sel);
    return sel inside {ALU_DIV, ALU_REM};
  endfunction

  function automatic logic is_rem(input logic [4:0] sel);
    return sel inside {ALU_REM, ALU_REMU};
  endfunction

endpackage

// File: rtl/muldiv_sequencer_div_step.sv
// One restoring-division step: shift {rem,quo} left, compare against the
// divisor, subtract and set the quotient LSB when the divisor fits.
module muldiv_sequencer_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;
  logic          fits;

  // rem < divisor before the shift, so diff always fits in XLEN+1 signed bits
  // and its top bit is a clean borrow flag.
  always_comb begin
    rem_sh   = {rem, quo[XLEN-1]};
    diff     = rem_sh - {1'b0, divisor};
    fits     = ~diff[XLEN];
    rem_next = fits ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_next = {quo[XLEN-2:0], fits};
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M controller: registered 33x33 multiply or 32-step restoring
// divide, stalling the pipeline while busy and strobing done with the result.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [4:0]      alu_sel,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            kill,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   a_q, b_q, quo_q, rem_q, dvs_q, result_q;
  logic [4:0]        sel_q;
  logic [CW-1:0]     count_q;

  logic              accept, div_zero, div_ovf;
  logic [XLEN-1:0]   rem_nx, quo_nx, quo_fix, rem_fix;
  logic signed [XLEN:0]     mul_a, mul_b;
  logic signed [2*XLEN-1:0] prod;

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? -v : v;
  endfunction

  assign accept   = (state_q == S_IDLE) && start && is_m_op(alu_sel) && !kill;
  assign div_zero = (op_b == '0);
  assign div_ovf  = is_signed_div(alu_sel) && (op_a == {1'b1, {(XLEN-1){1'b0}}})
                    && (op_b == '1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:
        if (accept) begin
          if (is_mul_op(alu_sel))       state_d = S_MUL;
          else if (div_zero || div_ovf) state_d = S_DONE;
          else                          state_d = S_DIV;
        end
      S_MUL:  state_d = kill ? S_IDLE : S_DONE;
      S_DIV:
        if (kill)                             state_d = S_IDLE;
        else if (count_q == CW'(XLEN - 1))    state_d = S_FIX;
      S_FIX:  state_d = kill ? S_IDLE : S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Only the low 2*XLEN bits of the 66-bit signed product are ever selected,
  // and those are identical to a 2*XLEN-bit wrap-around product.
  always_comb begin
    mul_a = {(sel_q != ALU_MULHU) & a_q[XLEN-1], a_q};
    mul_b = {((sel_q == ALU_MUL) || (sel_q == ALU_MULH)) & b_q[XLEN-1], b_q};
    prod  = (2*XLEN)'(mul_a) * (2*XLEN)'(mul_b);
  end

  muldiv_sequencer_div_step #(.XLEN(XLEN)) u_div_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  always_comb begin
    quo_fix = (is_signed_div(sel_q) && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -quo_q : quo_q;
    rem_fix = (is_signed_div(sel_q) && a_q[XLEN-1]) ? -rem_q : rem_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE:
          if (accept) begin
            a_q     <= op_a;
            b_q     <= op_b;
            sel_q   <= alu_sel;
            count_q <= '0;
            rem_q   <= '0;
            quo_q   <= is_signed_div(alu_sel) ? mag(op_a) : op_a;
            dvs_q   <= is_signed_div(alu_sel) ? mag(op_b) : op_b;
            if (!is_mul_op(alu_sel)) begin
              if (div_zero)     result_q <= is_rem(alu_sel) ? op_a : '1;
              else if (div_ovf) result_q <= is_rem(alu_sel) ? '0 : op_a;
            end
          end
        S_MUL:
          if (!kill)
            result_q <= (sel_q == ALU_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        S_DIV:
          if (!kill) begin
            rem_q   <= rem_nx;
            quo_q   <= quo_nx;
            count_q <= count_q + 1'b1;
          end
        S_FIX:
          if (!kill) result_q <= is_rem(sel_q) ? rem_fix : quo_fix;
        default: ;
      endcase
    end
  end

  // Gated by rst_n so an asserted reset drops the stall even with start high.
  assign stall  = rst_n && (accept || (state_q inside {S_MUL, S_DIV, S_FIX}));
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed and randomized checks of muldiv_sequencer: results via a scoreboard
// queue, done latency, stall length, kill/reset aborts and non-M codes.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [4:0]  alu_sel = ALU_ADD;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        stall, done;
  logic [31:0] result;

  int          passed = 0;
  int          total = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res = '0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .alu_sel (alu_sel),
    .op_a    (op_a),
    .op_b    (op_b),
    .kill    (kill),
    .stall   (stall),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_op(input logic [4:0] sel, input logic [31:0] a, b);
    logic [63:0] p;
    longint      sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (sel)
      ALU_MUL:    begin p = sa * sb; return p[31:0]; end
      ALU_MULH:   begin p = sa * sb; return p[63:32]; end
      ALU_MULHSU: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      ALU_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      ALU_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      ALU_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      ALU_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      ALU_REMU: return (b == 0) ? a : a % b;
      default:  return 32'h0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [4:0] sel, input logic [31:0] a, b);
    if (is_mul_op(sel)) return 2;
    if (b == 0) return 1;
    if (is_signed_div(sel) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Drives one instruction with start held until done, then checks latency,
  // stall length, scoreboard result and the single-cycle done strobe.
  task automatic run_op(input string tag, input logic [4:0] sel,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_cyc);
    int          got, stalls;
    logic [31:0] r;
    exp_q.push_back(exp_res);
    @(negedge clk);
    start = 1'b1; alu_sel = sel; op_a = a; op_b = b;
    #1;
    got = -1; stalls = 0;
    for (int c = 0; c < 60; c++) begin
      if (stall) stalls++;
      if (done) begin got = c; break; end
      if (c == 1) begin op_a = ~a; op_b = a ^ b; end
      @(negedge clk); #1;
    end
    start = 1'b0;
    check({tag, " done_cycle"}, 32'(got), 32'(exp_cyc));
    check({tag, " stall_cycles"}, 32'(stalls), 32'(exp_cyc));
    r = exp_q.pop_front();
    if (got >= 0) check({tag, " result"}, result, r);
    last_res = r;
    @(negedge clk); #1;
    check({tag, " done_one_cycle"}, {31'b0, done}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hits_stall, hits_done;
    logic [4:0]  rs;
    logic [31:0] ra, rb;

    start = 1'b1; alu_sel = ALU_MUL;
    repeat (2) @(negedge clk);
    #1;
    check("reset stall", {31'b0, stall}, 32'h0);
    check("reset done", {31'b0, done}, 32'h0);
    check("reset result", result, 32'h0);
    start = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    run_op("mul_7_m3", ALU_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);
    run_op("mulhu", ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
    run_op("mulh", ALU_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2);
    run_op("mulhsu", ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
    run_op("div_m7_2", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run_op("rem_m7_2", ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run_op("divu_100_7", ALU_DIVU, 32'd100, 32'd7, 32'd14, 34);
    run_op("remu_100_7", ALU_REMU, 32'd100, 32'd7, 32'd2, 34);
    run_op("divu_5_0", ALU_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem_5_0", ALU_REM, 32'd5, 32'd0, 32'd5, 1);
    run_op("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

    // kill during a divide
    run_op("pre_kill", ALU_DIVU, 32'd1000, 32'd10, 32'd100, 34);
    @(negedge clk);
    start = 1'b1; alu_sel = ALU_DIVU; op_a = 32'd100; op_b = 32'd7;
    repeat (10) @(negedge clk);
    start = 1'b0; kill = 1'b1;
    #1;
    check("kill stall_c10", {31'b0, stall}, 32'h1);
    @(negedge clk); #1;
    check("kill idle_stall", {31'b0, stall}, 32'h0);
    check("kill no_done", {31'b0, done}, 32'h0);
    check("kill result_kept", result, last_res);
    kill = 1'b0;
    hits_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (done) hits_done++;
    end
    check("kill no_late_done", 32'(hits_done), 32'h0);
    run_op("mul_3_4", ALU_MUL, 32'd3, 32'd4, 32'd12, 2);

    // asynchronous reset during a divide
    @(negedge clk);
    start = 1'b1; alu_sel = ALU_DIV; op_a = 32'd12345; op_b = 32'd17;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid stall", {31'b0, stall}, 32'h0);
    check("rst_mid done", {31'b0, done}, 32'h0);
    check("rst_mid result", result, 32'h0);
    start = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // kill and start together in IDLE
    @(negedge clk);
    start = 1'b1; alu_sel = ALU_MUL; op_a = 32'd5; op_b = 32'd6; kill = 1'b1;
    #1;
    check("kill_start stall", {31'b0, stall}, 32'h0);
    @(negedge clk); #1;
    check("kill_start no_accept", {31'b0, stall | done}, 32'h0);
    start = 1'b0; kill = 1'b0;

    // non-M code never stalls or completes
    @(negedge clk);
    start = 1'b1; alu_sel = ALU_ADD; op_a = 32'd1; op_b = 32'd2;
    hits_stall = 0; hits_done = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (stall) hits_stall++;
      if (done) hits_done++;
      @(negedge clk);
    end
    start = 1'b0;
    check("alu_add stall", 32'(hits_stall), 32'h0);
    check("alu_add done", 32'(hits_done), 32'h0);

    // M-op held across DONE: exactly one done overall
    run_op("held_divu", ALU_DIVU, 32'd81, 32'd9, 32'd9, 34);
    hits_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (done) hits_done++;
    end
    check("held single_done", 32'(hits_done), 32'h0);

    for (int i = 0; i < 8; i++) begin
      rs = 5'(ALU_MUL + 5'(i));
      ra = (i % 2 == 0) ? $urandom : 32'($urandom_range(0, 500)) - 32'd250;
      rb = (i % 3 == 0) ? 32'($urandom_range(0, 40)) - 32'd20 : $urandom;
      run_op("rand", rs, ra, rb, ref_op(rs, ra, rb), ref_lat(rs, ra, rb));
    end

    check("scoreboard empty", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
